// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and constant helper functions for the
// serial Hamming(15,11) decoder.
package hamming_pkg;

   localparam int CW_W   = 15;
   localparam int DATA_W = 11;
   localparam int SYN_W  = 4;

   // Codeword indices holding the parity bits (Hamming positions 1,2,4,8).
   localparam int P0_IDX = 0;
   localparam int P1_IDX = 1;
   localparam int P2_IDX = 3;
   localparam int P3_IDX = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_SHIFT  = 2'd2
   } state_e;

   // Codeword bits covered by syndrome bit k: positions (index+1) with bit k set.
   function automatic logic [CW_W-1:0] syn_mask(input int k);
      logic [CW_W-1:0] m;
      m = '0;
      for (int i = 0; i < CW_W; i++) begin
         m[i] = ((((i + 1) >> k) & 1) != 0);
      end
      return m;
   endfunction

   // Codeword index carrying data bit j (the j-th non-parity index, ascending).
   function automatic int data_idx(input int j);
      int n;
      int r;
      n = 0;
      r = 0;
      for (int i = 0; i < CW_W; i++) begin
         if (!(i == P0_IDX || i == P1_IDX || i == P2_IDX || i == P3_IDX)) begin
            if (n == j) begin
               r = i;
            end
            n++;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/hamming15_correct.sv
// Combinational Hamming(15,11) syndrome computation and single-error
// correction of the data bits.
module hamming15_correct
   import hamming_pkg::*;
(
   input  logic [CW_W-1:0]   cw_i,
   output logic [SYN_W-1:0]  syn_o,
   output logic [DATA_W-1:0] data_o
);

   // Each syndrome bit is the parity over the positions it covers.
   for (genvar gi = 0; gi < SYN_W; gi++) begin : g_syn
      localparam logic [CW_W-1:0] MASK = syn_mask(gi);
      assign syn_o[gi] = ^(cw_i & MASK);
   end

   // A data bit is flipped when the syndrome points at its position; the
   // parity bits themselves are never needed downstream, so only data bits
   // are corrected.
   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam int IDX = data_idx(gi);
      assign data_o[gi] = cw_i[IDX] ^ (syn_o == SYN_W'(IDX + 1));
   end

endmodule

// File: rtl/hamming_decoder_serial.sv
// Serial Hamming(15,11) decoder: assembles 15 serial codeword beats, corrects
// a single-bit error and shifts the 11 data bits out serially.
// Optional: define HAMMING_ERR_COUNT_EN to add the saturating err_count output.
module hamming_decoder_serial
   import hamming_pkg::*;
#(
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sync,
   output logic             dout,
   output logic             dout_valid,
   output logic             err_corrected,
   output logic [SYN_W-1:0] syndrome
`ifdef HAMMING_ERR_COUNT_EN
   ,
   output logic [15:0]      err_count
`endif
);

   logic [3:0]        bit_cnt_q;
   logic [CW_W-1:0]   in_sr_q;
   logic [CW_W-1:0]   in_sr_d;
   logic [CW_W-1:0]   cw_q;
   logic [3:0]        wr_idx;
   logic              last_beat;
   state_e            state_q;
   state_e            state_d;
   logic              load_out;
   logic              shift_out;
   logic [DATA_W-1:0] out_sr_q;
   logic [DATA_W-1:0] out_sr_shifted;
   logic [DATA_W-1:0] data_c;
   logic [3:0]        out_cnt_q;
   logic [SYN_W-1:0]  syn_c;
   logic [SYN_W-1:0]  syndrome_q;
   logic              err_q;

   // sync wins over a coincident beat, so such a beat never completes a frame.
   assign last_beat = din_valid && !sync && (bit_cnt_q == 4'd14);
   // Each beat is written straight into its codeword position.
   assign wr_idx    = (MSB_FIRST != 0) ? (4'd14 - bit_cnt_q) : bit_cnt_q;

   // Assembly register with the current beat merged in.
   always_comb begin
      in_sr_d         = in_sr_q;
      in_sr_d[wr_idx] = din;
   end

   // Input beat counter, codeword assembly and full-codeword latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q <= '0;
         in_sr_q   <= '0;
         cw_q      <= '0;
      end else if (sync) begin
         bit_cnt_q <= '0;
      end else if (din_valid) begin
         in_sr_q <= in_sr_d;
         if (last_beat) begin
            bit_cnt_q <= '0;
            cw_q      <= in_sr_d;
         end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
      end
   end

   hamming15_correct u_correct (
      .cw_i   (cw_q),
      .syn_o  (syn_c),
      .data_o (data_c)
   );

   // Output FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output FSM next state: one decode cycle, then eleven shift cycles.
   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      shift_out = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (last_beat) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            load_out = 1'b1;
            state_d  = ST_SHIFT;
         end
         ST_SHIFT: begin
            shift_out = 1'b1;
            if (out_cnt_q == 4'(DATA_W - 1)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign out_sr_shifted = (MSB_FIRST != 0) ? {out_sr_q[DATA_W-2:0], 1'b0}
                                            : {1'b0, out_sr_q[DATA_W-1:1]};

   // Corrected data / syndrome capture and serial output shifting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_sr_q   <= '0;
         out_cnt_q  <= '0;
         syndrome_q <= '0;
         err_q      <= 1'b0;
      end else if (load_out) begin
         out_sr_q   <= data_c;
         out_cnt_q  <= '0;
         syndrome_q <= syn_c;
         err_q      <= |syn_c;
      end else if (shift_out) begin
         out_sr_q  <= out_sr_shifted;
         out_cnt_q <= out_cnt_q + 4'd1;
      end
   end

   assign dout_valid    = (state_q == ST_SHIFT);
   assign dout          = dout_valid & ((MSB_FIRST != 0) ? out_sr_q[DATA_W-1] : out_sr_q[0]);
   assign syndrome      = syndrome_q;
   assign err_corrected = err_q;

`ifdef HAMMING_ERR_COUNT_EN
   logic [15:0] err_count_q;

   // Saturating count of frames that needed correction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count_q <= '0;
      end else if (load_out && (syn_c != '0) && (err_count_q != 16'hFFFF)) begin
         err_count_q <= err_count_q + 16'd1;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule
